// File: rtl/keyload_pkg.sv
// Shared types and helpers for the key-generation input loader.
package keyload_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoadP,
    StLoadQ,
    StFlush,
    StKick,
    StWaitKg,
    StDone
  } state_e;

  // Stream words needed to build one prime (half the key width).
  function automatic int unsigned words_per_prime(input int unsigned data_width,
                                                  input int unsigned in_width);
    return (data_width / 2) / in_width;
  endfunction

  // Configuration sanity: batch fits the RAM and stream words tile a prime exactly.
  function automatic bit cfg_ok(input int unsigned data_width, input int unsigned addr_width,
                                input int unsigned file_size, input int unsigned in_width);
    return (file_size >= 1) && (longint'(file_size) <= (longint'(1) << addr_width)) &&
           (in_width != 0) && (((data_width / 2) % in_width) == 0);
  endfunction

endpackage

// File: rtl/key_input_loader_word_assembler.sv
// Collects IN_WIDTH stream words, LSW first, into one OUT_WIDTH word.
module word_assembler #(
  parameter int unsigned IN_WIDTH  = 32,
  parameter int unsigned OUT_WIDTH = 512
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 accept,
  input  logic [IN_WIDTH-1:0]  in_data,
  output logic                 full,
  output logic [OUT_WIDTH-1:0] word
);

  localparam int unsigned Wpp  = OUT_WIDTH / IN_WIDTH;
  localparam int unsigned CntW = (Wpp > 1) ? $clog2(Wpp) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(Wpp - 1);

  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;

  // Drop the accepted word into its slot and advance the wrapping word counter.
  always_comb begin
    data_d = data_q;
    cnt_d  = cnt_q;
    for (int i = 0; i < int'(Wpp); i++) begin
      if (accept && (cnt_q == CntW'(i))) data_d[i*IN_WIDTH +: IN_WIDTH] = in_data;
    end
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      cnt_d = (cnt_q == LastCnt) ? '0 : cnt_q + CntW'(1);
    end
  end

  // The full pulse and word are combinational so the parent can register the RAM write.
  always_comb begin
    full = accept && (cnt_q == LastCnt);
    word = data_d;
  end

  // Counter and assembly register; both hold while nothing is accepted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

endmodule

// File: rtl/key_input_loader.sv
// Loads FILE_SIZE (p,q) prime pairs from a word stream into the input RAMs,
// then kicks key generation and waits for it to finish.
// Optional build macro KEYLOAD_ODD_CHECK_EN: flags even primes in err and skips the kick.
module key_input_loader
  import keyload_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 1024,
  parameter int unsigned RAM_ADDR_WIDTH = 5,
  parameter int unsigned FILE_SIZE      = 32,
  parameter int unsigned IN_WIDTH       = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      load_start,
  input  logic [IN_WIDTH-1:0]       in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_WIDTH/2-1:0]   p_din,
  output logic [RAM_ADDR_WIDTH-1:0] p_wr_addr,
  output logic                      p_wr_en,
  output logic [DATA_WIDTH/2-1:0]   q_din,
  output logic [RAM_ADDR_WIDTH-1:0] q_wr_addr,
  output logic                      q_wr_en,
  output logic                      kg_start,
  input  logic                      kg_done,
  output logic                      busy,
  output logic                      done,
  output logic                      err
);

  localparam int unsigned HalfW = DATA_WIDTH / 2;
  localparam int unsigned Wpp   = words_per_prime(DATA_WIDTH, IN_WIDTH);
  localparam logic [RAM_ADDR_WIDTH-1:0] LastK = RAM_ADDR_WIDTH'(FILE_SIZE - 1);

  if (!cfg_ok(DATA_WIDTH, RAM_ADDR_WIDTH, FILE_SIZE, IN_WIDTH) || (Wpp * IN_WIDTH != HalfW))
  begin : g_bad_cfg
    $error("key_input_loader: FILE_SIZE exceeds RAM depth or IN_WIDTH does not divide prime");
  end

  state_e state_q, state_d;
  logic [RAM_ADDR_WIDTH-1:0] k_q, k_d;
  logic [HalfW-1:0]          p_din_q, p_din_d, q_din_q, q_din_d;
  logic [RAM_ADDR_WIDTH-1:0] p_addr_q, p_addr_d, q_addr_q, q_addr_d;
  logic                      p_wr_q, p_wr_d, q_wr_q, q_wr_d;

  logic             p_accept, q_accept, clear;
  logic             p_full, q_full;
  logic [HalfW-1:0] p_word, q_word;

  assign p_accept = in_valid && (state_q == StLoadP);
  assign q_accept = in_valid && (state_q == StLoadQ);
  // A new batch may only begin from IDLE or DONE.
  assign clear    = load_start && ((state_q == StIdle) || (state_q == StDone));

  word_assembler #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(HalfW)) u_p_asm (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .accept  (p_accept),
    .in_data (in_data),
    .full    (p_full),
    .word    (p_word)
  );

  word_assembler #(.IN_WIDTH(IN_WIDTH), .OUT_WIDTH(HalfW)) u_q_asm (
    .clock   (clock),
    .reset   (reset),
    .clear   (clear),
    .accept  (q_accept),
    .in_data (in_data),
    .full    (q_full),
    .word    (q_word)
  );

`ifdef KEYLOAD_ODD_CHECK_EN
  logic err_q, err_d;
`endif

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (load_start) state_d = StLoadP;
      StLoadP:  if (p_full) state_d = StLoadQ;
      StLoadQ:  if (q_full) state_d = (k_q != LastK) ? StLoadP : StFlush;
`ifdef KEYLOAD_ODD_CHECK_EN
      StFlush:  state_d = err_q ? StDone : StKick;
`else
      StFlush:  state_d = StKick;
`endif
      StKick:   state_d = StWaitKg;
      StWaitKg: if (kg_done) state_d = StDone;
      StDone:   if (load_start) state_d = StLoadP;
      default:  state_d = StIdle;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    in_ready = (state_q == StLoadP) || (state_q == StLoadQ);
    busy     = (state_q != StIdle) && (state_q != StDone);
    done     = (state_q == StDone);
    kg_start = (state_q == StKick);
  end

  // RAM write registers and the entry index; k advances with each completed q.
  always_comb begin
    k_d      = k_q;
    p_din_d  = p_full ? p_word : p_din_q;
    q_din_d  = q_full ? q_word : q_din_q;
    p_addr_d = p_full ? k_q : p_addr_q;
    q_addr_d = q_full ? k_q : q_addr_q;
    p_wr_d   = p_full;
    q_wr_d   = q_full;
    if (clear) begin
      k_d = '0;
    end else if (q_full && (k_q != LastK)) begin
      k_d = k_q + RAM_ADDR_WIDTH'(1);
    end
  end

`ifdef KEYLOAD_ODD_CHECK_EN
  // Sticky even-prime flag; bit 0 of the assembled word is bit 0 of word 0.
  always_comb begin
    err_d = err_q;
    if (clear) begin
      err_d = 1'b0;
    end else if ((p_full && !p_word[0]) || (q_full && !q_word[0])) begin
      err_d = 1'b1;
    end
  end

  // Error flag register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Datapath registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      k_q      <= '0;
      p_din_q  <= '0;
      q_din_q  <= '0;
      p_addr_q <= '0;
      q_addr_q <= '0;
      p_wr_q   <= 1'b0;
      q_wr_q   <= 1'b0;
    end else begin
      k_q      <= k_d;
      p_din_q  <= p_din_d;
      q_din_q  <= q_din_d;
      p_addr_q <= p_addr_d;
      q_addr_q <= q_addr_d;
      p_wr_q   <= p_wr_d;
      q_wr_q   <= q_wr_d;
    end
  end

  assign p_din     = p_din_q;
  assign q_din     = q_din_q;
  assign p_wr_addr = p_addr_q;
  assign q_wr_addr = q_addr_q;
  assign p_wr_en   = p_wr_q;
  assign q_wr_en   = q_wr_q;

endmodule

// File: tb/tb_key_input_loader.sv
// Self-checking bench for key_input_loader: table of batch scenarios plus
// hand-written reset / ignored-input sequences, checked against a word-level model.
module tb_key_input_loader;

  localparam int DW  = 1024;
  localparam int AW  = 5;
  localparam int FS  = 32;
  localparam int IW  = 32;
  localparam int HW  = DW / 2;
  localparam int WPP = HW / IW;
`ifdef KEYLOAD_ODD_CHECK_EN
  localparam bit OddChk = 1'b1;
`else
  localparam bit OddChk = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          load_start = 1'b0;
  logic [IW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [HW-1:0] p_din, q_din;
  logic [AW-1:0] p_wr_addr, q_wr_addr;
  logic          p_wr_en, q_wr_en;
  logic          kg_start;
  logic          kg_done = 1'b0;
  logic          busy, done, err;

  key_input_loader dut (
    .clock      (clock),
    .reset      (reset),
    .load_start (load_start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .p_din      (p_din),
    .p_wr_addr  (p_wr_addr),
    .p_wr_en    (p_wr_en),
    .q_din      (q_din),
    .q_wr_addr  (q_wr_addr),
    .q_wr_en    (q_wr_en),
    .kg_start   (kg_start),
    .kg_done    (kg_done),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clock = ~clock;

  int unsigned cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;
  bit stream_dead = 0;

  task automatic check(input string name, input logic [HW-1:0] act, input logic [HW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: stream words per entry and the primes they spell.
  logic [IW-1:0] wp[FS][WPP];
  logic [IW-1:0] wq[FS][WPP];
  logic [HW-1:0] mp[FS];
  logic [HW-1:0] mq[FS];

  task automatic build_model(input int mode, input int even);
    for (int k = 0; k < FS; k++) begin
      for (int i = 0; i < WPP; i++) begin
        if (mode == 0) begin
          // p = 2^511 + 2k+1, q = 3*2^510 + 2k+3
          wp[k][i] = (i == 0) ? IW'(2 * k + 1) : (i == WPP - 1) ? 32'h8000_0000 : '0;
          wq[k][i] = (i == 0) ? IW'(2 * k + 3) : (i == WPP - 1) ? 32'hC000_0000 : '0;
        end else begin
          wp[k][i] = $urandom;
          wq[k][i] = $urandom;
        end
      end
      wp[k][0][0] = (k != even);
      wq[k][0][0] = 1'b1;
      mp[k] = '0;
      mq[k] = '0;
      for (int i = 0; i < WPP; i++) begin
        mp[k] = mp[k] | (HW'(wp[k][i]) << (i * IW));
        mq[k] = mq[k] | (HW'(wq[k][i]) << (i * IW));
      end
    end
  endtask

  // Write monitor.
  int            pa[$], qa[$];
  logic [HW-1:0] pd[$], qd[$];
  bit            pe[$], qe[$];
  int            kick_n = 0;
  int unsigned   kick_cyc = 0, last_q_cyc = 0;

  always @(negedge clock) begin
    if (!reset) begin
      if (p_wr_en) begin pa.push_back(int'(p_wr_addr)); pd.push_back(p_din); pe.push_back(err); end
      if (q_wr_en) begin qa.push_back(int'(q_wr_addr)); qd.push_back(q_din); qe.push_back(err);
        last_q_cyc = cyc; end
      if (kg_start) begin kick_n++; kick_cyc = cyc; end
    end
  end

  // Offer one word after a random idle gap; called and returns at a falling edge.
  task automatic send_word(input logic [IW-1:0] w, input int gap, input bit ls);
    int t = 0;
    if (stream_dead) return;
    while (int'($urandom_range(99)) < gap) begin
      in_valid = 1'b0;
      in_data  = $urandom;
      @(negedge clock);
    end
    in_valid   = 1'b1;
    in_data    = w;
    load_start = ls;
    while (!in_ready && t < 50) begin
      @(negedge clock);
      load_start = 1'b0;
      t++;
    end
    if (t >= 50) begin
      checks++;
      errors++;
      stream_dead = 1;
      $display("FAIL accept_timeout: in_ready stayed 0, required 1");
    end
    @(negedge clock);
    in_valid   = 1'b0;
    load_start = 1'b0;
  endtask

  task automatic stream_entry(input int k, input int nq, input int gap, input bit ls_glitch);
    for (int i = 0; i < WPP; i++) send_word(wp[k][i], gap, 1'b0);
    for (int i = 0; i < nq; i++) send_word(wq[k][i], gap, ls_glitch && (k == 1) && (i == 0));
  endtask

  task automatic pulse_start();
    pa.delete(); pd.delete(); pe.delete();
    qa.delete(); qd.delete(); qe.delete();
    kick_n = 0;
    load_start = 1'b1;
    @(negedge clock);
    load_start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
    check("err_cleared", err, 0);
  endtask

  task automatic run_batch(input int mode, input int gap, input int even, input int hold,
                           input bit ls_glitch, input bit exp_err);
    int t = 0;
    int viol = 0;
    build_model(mode, even);
    pulse_start();
    for (int k = 0; k < FS; k++) stream_entry(k, WPP, gap, ls_glitch);
    while (!(kg_start || done) && t < 20) begin
      @(negedge clock);
      t++;
    end
    check("flush_latency", t, 1);
    if (exp_err) begin
      check("err_path_done", done, 1);
      check("err_path_no_kick", kg_start, 0);
      check("err_path_err", err, 1);
    end else begin
      check("kick_seen", kg_start, 1);
      for (int n = 0; n < hold; n++) begin
        load_start = ls_glitch && (n == 2);
        @(negedge clock);
        if (busy !== 1'b1 || done !== 1'b0 || in_ready !== 1'b0 || kg_start !== 1'b0) viol++;
      end
      load_start = 1'b0;
      check("wait_kg_hold", viol, 0);
      kg_done = 1'b1;
      @(negedge clock);
      kg_done = 1'b0;
      check("done_after_kg_done", done, 1);
      check("busy_after_kg_done", busy, 0);
      check("kick_count", kick_n, 1);
      check("kick_after_last_q", kick_cyc, last_q_cyc + 1);
    end
    @(negedge clock);
    check("p_write_count", pa.size(), FS);
    check("q_write_count", qa.size(), FS);
    for (int k = 0; k < FS && k < pa.size() && k < qa.size(); k++) begin
      check($sformatf("p_addr[%0d]", k), pa[k], k);
      check($sformatf("p_data[%0d]", k), pd[k], mp[k]);
      check($sformatf("p_err[%0d]", k), pe[k], OddChk && even >= 0 && k >= even);
      check($sformatf("q_addr[%0d]", k), qa[k], k);
      check($sformatf("q_data[%0d]", k), qd[k], mq[k]);
      check($sformatf("q_err[%0d]", k), qe[k], OddChk && even >= 0 && k >= even);
    end
    check("final_err", err, exp_err);
  endtask

  typedef struct {
    int mode;
    int gap;
    int even;
    int hold;
    bit ls_glitch;
    bit exp_err;
  } case_t;

  case_t cases[4];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    cases[0] = '{mode: 0, gap: 0,  even: -1, hold: 100, ls_glitch: 1'b0, exp_err: 1'b0};
    cases[1] = '{mode: 1, gap: 50, even: -1, hold: 5,   ls_glitch: 1'b1, exp_err: 1'b0};
    cases[2] = '{mode: 1, gap: 20, even: 3,  hold: 4,   ls_glitch: 1'b0, exp_err: OddChk};
    cases[3] = '{mode: 1, gap: 0,  even: -1, hold: 2,   ls_glitch: 1'b1, exp_err: 1'b0};

    repeat (3) @(negedge clock);
    check("rst_p_wr_en", p_wr_en, 0);
    check("rst_q_wr_en", q_wr_en, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_kg_start", kg_start, 0);
    check("rst_err", err, 0);
    check("rst_p_din", p_din, 0);
    reset = 1'b0;
    @(negedge clock);

    // kg_done while idle must not complete anything.
    kg_done = 1'b1;
    @(negedge clock);
    kg_done = 1'b0;
    @(negedge clock);
    check("idle_kg_done_done", done, 0);
    check("idle_kg_done_busy", busy, 0);

    for (int c = 0; c < 4; c++) begin
      run_batch(cases[c].mode, cases[c].gap, cases[c].even, cases[c].hold,
                cases[c].ls_glitch, cases[c].exp_err);
    end

    // Reset partway through q of entry 5.
    build_model(1, -1);
    pulse_start();
    for (int k = 0; k < 5; k++) stream_entry(k, WPP, 10, 1'b0);
    stream_entry(5, WPP / 2, 10, 1'b0);
    reset = 1'b1;
    #1;
    check("midrst_p_wr_en", p_wr_en, 0);
    check("midrst_q_wr_en", q_wr_en, 0);
    check("midrst_q_din", q_din, 0);
    check("midrst_q_addr", q_wr_addr, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    for (int n = 0; n < 3; n++) begin
      in_valid = 1'b1;
      @(negedge clock);
      check("post_rst_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    run_batch(1, 30, -1, 3, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/key_input_loader.md
Name: key_input_loader

Overview:
- Upstream feeder for the key-generation stage.
- Accepts primes p and q as a narrow valid/ready word stream and assembles each prime into one DATA_WIDTH/2-bit word.
- Writes the assembled words into the p and q input RAMs, one entry per address.
- After FILE_SIZE entry pairs are loaded, pulses start to key generation, waits for its done, and reports completion.

Parameters:
- DATA_WIDTH, 1024, key width; each prime is DATA_WIDTH/2 bits.
- RAM_ADDR_WIDTH, 5, input-RAM address width.
- FILE_SIZE, 32, number of (p,q) entries per batch; must be ≤ 2**RAM_ADDR_WIDTH.
- IN_WIDTH, 32, stream word width; must divide DATA_WIDTH/2.

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_start  in  1  one-cycle pulse that begins a batch.
- in_data  in  IN_WIDTH  stream word.
- in_valid  in  1  in_data valid.
- in_ready  out  1  loader accepts a word this cycle.
- p_din  out  DATA_WIDTH/2  assembled p to the p RAM.
- p_wr_addr  out  RAM_ADDR_WIDTH  p RAM write address.
- p_wr_en  out  1  p RAM write strobe.
- q_din  out  DATA_WIDTH/2  assembled q to the q RAM.
- q_wr_addr  out  RAM_ADDR_WIDTH  q RAM write address.
- q_wr_en  out  1  q RAM write strobe.
- kg_start  out  1  start pulse to key generation.
- kg_done  in  1  done from key generation.
- busy  out  1  batch in progress.
- done  out  1  batch complete.
- err  out  1  sticky error flag.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: all outputs 0, state IDLE, counters 0. Reset mid-batch aborts the batch; RAM contents are left as written.
- Derived values: WPP = (DATA_WIDTH/2)/IN_WIDTH words per prime.
- Stream order per entry k = 0..FILE_SIZE-1: WPP words of p, least significant word first, then WPP words of q.
- Handshake: a word is accepted when in_valid && in_ready. in_ready = 1 only in LOAD_P and LOAD_Q.
- Assembly: each accepted word is placed at bit offset word_cnt*IN_WIDTH of the assembly register. word_cnt wraps 0..WPP-1.
- p write: on acceptance of word WPP-1 of p, the next cycle drives p_wr_en=1 for exactly one cycle, with p_din = assembled value and p_wr_addr = k. This write may coincide with acceptance of the first q word.
- q write: same rule, using q_wr_en, q_din and q_wr_addr = k; k then increments.
- Write outputs are registered. p_din and q_din hold their last values when not strobed.
- FSM:
  - IDLE: load_start → LOAD_P; busy=0.
  - LOAD_P: last p word accepted → LOAD_Q.
  - LOAD_Q: last q word accepted → LOAD_P if k < FILE_SIZE-1, else FLUSH.
  - FLUSH: final q write cycle → KICK.
  - KICK: kg_start=1 for one cycle → WAIT_KG.
  - WAIT_KG: kg_done=1 → DONE.
  - DONE: done=1, held; load_start → LOAD_P, clearing done, err and counters.
- busy = 1 in every state except IDLE and DONE.
- load_start is ignored in LOAD_P, LOAD_Q, FLUSH, KICK and WAIT_KG.
- kg_start rises exactly one cycle after the final q_wr_en, so the final write is in RAM before key generation reads it.
- kg_done asserted outside WAIT_KG is ignored.
- A stalled stream (in_valid=0) holds all counters and the assembly register.

Optional Feature:
- Macro: KEYLOAD_ODD_CHECK_EN.
- Defined: bit 0 of word 0 of every prime is checked. If it is 0 (even prime), err is set sticky. The write still occurs. At the end of the batch FLUSH goes directly to DONE, skipping KICK, so kg_start never pulses.
- Undefined: err is tied 0; FLUSH always goes to KICK.

Decomposition:
- Package keyload_pkg holds:
  - state enum: IDLE, LOAD_P, LOAD_Q, FLUSH, KICK, WAIT_KG, DONE;
  - function computing WPP;
  - elaboration-time checks on FILE_SIZE and IN_WIDTH.
- Sub-module word_assembler (parameters IN_WIDTH, OUT_WIDTH): contains the word counter and assembly register, and outputs a one-cycle "full" pulse with the assembled word.
- Two instances: one for p, one for q.

Test Plan:
1. Reset, then load_start with defaults. Stream p0 = 512'h1…0001 and q0 = 512'h3…0003 as 32-bit LSW-first words, continuing through 32 entries → 32 p_wr_en and 32 q_wr_en pulses at addresses 0..31 with exact 512-bit values; kg_start pulses once, one cycle after the q write at address 31.
2. Random in_valid gaps (about 50% duty) on entry 0 → assembled p/q are identical to the gap-free case; no extra write strobes.
3. Hold kg_done=0 for 100 cycles after kg_start → busy=1 and done=0 throughout. Pulse kg_done → done=1 next cycle, busy=0. A second load_start restarts at address 0.
4. Assert reset mid-way through the q of entry 5 → all outputs 0 immediately. After release, in_ready=0 until load_start; the next batch writes from address 0.
5. load_start pulsed during LOAD_Q and WAIT_KG → no state change; kg_done pulsed in IDLE → done stays 0.
6. With KEYLOAD_ODD_CHECK_EN defined, make entry 3's p even (LSB=0) → err=1 from the cycle of that p write; no kg_start; DONE is reached after FLUSH. Without the macro, the same stimulus gives err=0 and kg_start pulses.
